// File: rtl/img_disp_pkg.sv
// Shared command codes, FSM states and window home helper for the image display controller.
package img_disp_pkg;

  localparam logic [3:0] CMD_WR     = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_MAX    = 4'd5;
  localparam logic [3:0] CMD_MIN    = 4'd6;
  localparam logic [3:0] CMD_AVG    = 4'd7;
  localparam logic [3:0] CMD_CCR    = 4'd8;
  localparam logic [3:0] CMD_CR     = 4'd9;
  localparam logic [3:0] CMD_MRX    = 4'd10;
  localparam logic [3:0] CMD_MRY    = 4'd11;
  localparam logic [3:0] CMD_INV    = 4'd12;
  localparam logic [3:0] CMD_HOME   = 4'd13;
  localparam logic [3:0] CMD_RELOAD = 4'd14;

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_FIN} state_t;

  // Window top-left coordinate that centres the 2x2 window along one axis.
  function automatic int home_pos(input int dim);
    return dim / 2 - 1;
  endfunction

endpackage

// File: rtl/img_disp_ctrl_p_if.sv
// Host/ROM/RAM bundle of the image display controller.
interface img_disp_ctrl_p_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] rom_q;
  logic          rom_rd;
  logic [AW-1:0] rom_a;
  logic          ram_valid;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          busy;
  logic          done;

  modport master (output cmd, cmd_valid, rom_q,
                  input  rom_rd, rom_a, ram_valid, ram_a, ram_d, busy, done);
  modport slave  (input  cmd, cmd_valid, rom_q,
                  output rom_rd, rom_a, ram_valid, ram_a, ram_d, busy, done);
endinterface

// File: rtl/img_win_alu.sv
// Combinational 2x2 window operator: pixel order is P0 TL, P1 TR, P2 BL, P3 BR.
module img_win_alu import img_disp_pkg::*; #(
  parameter int DW = 8
) (
  input  logic [3:0]         cmd,
  input  logic [3:0][DW-1:0] pix_in,
  output logic [3:0][DW-1:0] pix_out
);
  logic [DW-1:0] mx, mn;
  logic [DW+1:0] sum;

  // Reduce the window to its max, min and full-width sum.
  always_comb begin
    mx  = pix_in[0];
    mn  = pix_in[0];
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (pix_in[i] > mx) mx = pix_in[i];
      if (pix_in[i] < mn) mn = pix_in[i];
      sum = sum + (DW+2)'(pix_in[i]);
    end
  end

  // Per-command remap; commands that do not touch pixels pass them through.
  always_comb begin
    pix_out = pix_in;
    case (cmd)
      CMD_MAX: pix_out = {4{mx}};
      CMD_MIN: pix_out = {4{mn}};
      CMD_AVG: pix_out = {4{sum[DW+1:2]}};
      CMD_CCR: begin
        pix_out[0] = pix_in[1]; pix_out[1] = pix_in[3];
        pix_out[3] = pix_in[2]; pix_out[2] = pix_in[0];
      end
      CMD_CR: begin
        pix_out[0] = pix_in[2]; pix_out[2] = pix_in[3];
        pix_out[3] = pix_in[1]; pix_out[1] = pix_in[0];
      end
      CMD_MRX: begin
        pix_out[0] = pix_in[2]; pix_out[2] = pix_in[0];
        pix_out[1] = pix_in[3]; pix_out[3] = pix_in[1];
      end
      CMD_MRY: begin
        pix_out[0] = pix_in[1]; pix_out[1] = pix_in[0];
        pix_out[2] = pix_in[3]; pix_out[3] = pix_in[2];
      end
      CMD_INV: pix_out = ~pix_in;
      default: ;
    endcase
  end
endmodule

// File: rtl/img_disp_ctrl_p.sv
// Image display controller: loads a frame from ROM, edits it via a 2x2 window, streams it to RAM.
module img_disp_ctrl_p import img_disp_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic clk,
  input  logic reset,
  img_disp_ctrl_p_if.slave bus
);
  localparam int N    = IMG_W * IMG_H;
  localparam int LAST = N - 1;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [XW-1:0] HOME_X = XW'(home_pos(IMG_W));
  localparam logic [YW-1:0] HOME_Y = YW'(home_pos(IMG_H));
  localparam logic [XW-1:0] X_LIM  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LIM  = YW'(IMG_H - 2);

  state_t              state;
  logic [3:0]          cmd_q;
  logic [AW:0]         ld_cnt;
  logic                cap_vld;
  logic [AW-1:0]       cap_a;
  logic [XW-1:0]       px, px1;
  logic [YW-1:0]       py, py1;
  logic [DW-1:0]       mem [N];
  logic [3:0][AW-1:0]  win_a;
  logic [3:0][DW-1:0]  pix_cur, pix_new;
  logic [AW-1:0]       nxt_a;
  logic                pix_op;

  // IMG_W is a power of two, so {y,x} is exactly y*IMG_W+x.
  assign px1      = px + XW'(1);
  assign py1      = py + YW'(1);
  assign win_a[0] = {py,  px};
  assign win_a[1] = {py,  px1};
  assign win_a[2] = {py1, px};
  assign win_a[3] = {py1, px1};
  assign nxt_a    = bus.ram_a + AW'(1);
  assign pix_op   = (cmd_q >= CMD_MAX) && (cmd_q <= CMD_INV);

  // Fetch the four window pixels for the operator.
  always_comb begin
    for (int i = 0; i < 4; i++) pix_cur[i] = mem[win_a[i]];
  end

  img_win_alu #(.DW(DW)) u_alu (
    .cmd     (cmd_q),
    .pix_in  (pix_cur),
    .pix_out (pix_new)
  );

  // ROM data trails its address by one cycle; remember which address is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld <= 1'b0;
      cap_a   <= '0;
    end else begin
      cap_vld <= bus.rom_rd;
      cap_a   <= bus.rom_a;
    end
  end

  // Frame buffer: one write port while loading, four while executing a pixel command.
  always_ff @(posedge clk) begin
    if (cap_vld) mem[cap_a] <= bus.rom_q;
    else if (state == S_EXEC && pix_op)
      for (int i = 0; i < 4; i++) mem[win_a[i]] <= pix_new[i];
  end

  // Control FSM with registered outputs and window position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_LOAD;
      cmd_q         <= '0;
      ld_cnt        <= '0;
      px            <= HOME_X;
      py            <= HOME_Y;
      bus.rom_rd    <= 1'b0;
      bus.rom_a     <= '0;
      bus.ram_valid <= 1'b0;
      bus.ram_a     <= '0;
      bus.ram_d     <= '0;
      bus.busy      <= 1'b1;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_cnt != N[AW:0]) begin
            bus.rom_rd <= 1'b1;
            bus.rom_a  <= ld_cnt[AW-1:0];
            ld_cnt     <= ld_cnt + 1'b1;
          end else begin
            bus.rom_rd <= 1'b0;
            bus.rom_a  <= '0;
            // leave once the final read's data has been captured
            if (!bus.rom_rd) begin
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state    <= S_EXEC;
            cmd_q    <= bus.cmd;
            bus.busy <= 1'b1;
          end
        end
        S_EXEC: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          case (cmd_q)
            CMD_WR: begin
              state         <= S_WRITE;
              bus.busy      <= 1'b1;
              bus.ram_valid <= 1'b1;
              bus.ram_a     <= '0;
              bus.ram_d     <= mem[0];
            end
            CMD_UP:    if (py != '0)   py <= py - YW'(1);
            CMD_DOWN:  if (py < Y_LIM) py <= py1;
            CMD_LEFT:  if (px != '0)   px <= px - XW'(1);
            CMD_RIGHT: if (px < X_LIM) px <= px1;
            CMD_HOME: begin
              px <= HOME_X;
              py <= HOME_Y;
            end
            CMD_RELOAD: begin
              state    <= S_LOAD;
              bus.busy <= 1'b1;
              ld_cnt   <= '0;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          if (bus.ram_a == LAST[AW-1:0]) begin
            state         <= S_FIN;
            bus.ram_valid <= 1'b0;
            bus.ram_a     <= '0;
            bus.ram_d     <= '0;
            bus.done      <= 1'b1;
          end else begin
            bus.ram_a <= nxt_a;
            bus.ram_d <= mem[nxt_a];
          end
        end
        S_FIN: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_img_disp_ctrl_p.sv
// Bench: two controllers (8x8x8 and 16x4x10) against a frame-level model.
module tb_img_disp_ctrl_p;
  import img_disp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  img_disp_ctrl_p_if #(.DW(8),  .AW(6)) ifa ();
  img_disp_ctrl_p_if #(.DW(10), .AW(6)) ifb ();

  img_disp_ctrl_p #(.IMG_W(8),  .IMG_H(8), .DW(8))  u_a (.clk(clk), .reset(reset), .bus(ifa));
  img_disp_ctrl_p #(.IMG_W(16), .IMG_H(4), .DW(10)) u_b (.clk(clk), .reset(reset), .bus(ifb));

  int rom  [2][64];
  int mdl  [2][64];
  int outb [2][64];
  int W [2] = '{8, 16};
  int H [2] = '{8, 4};
  int MV[2] = '{255, 1023};
  int mx[2], my[2];
  int lexp[2], wexp[2], dones[2];
  bit plast[2], pdone[2];
  int n_tests = 0, n_fail = 0;

  logic [1:0]  rr, rv, dn, bs;
  logic [31:0] roa[2], ra[2], rd[2];
  assign rr = {ifb.rom_rd, ifa.rom_rd};
  assign rv = {ifb.ram_valid, ifa.ram_valid};
  assign dn = {ifb.done, ifa.done};
  assign bs = {ifb.busy, ifa.busy};
  assign roa[0] = 32'(ifa.rom_a);
  assign roa[1] = 32'(ifb.rom_a);
  assign ra[0]  = 32'(ifa.ram_a);
  assign ra[1]  = 32'(ifb.ram_a);
  assign rd[0]  = 32'(ifa.ram_d);
  assign rd[1]  = 32'(ifb.ram_d);

  // Synchronous ROMs: data for the requested address appears the next cycle.
  always @(posedge clk) begin
    if (ifa.rom_rd) ifa.rom_q <= 8'(rom[0][ifa.rom_a]);
    if (ifb.rom_rd) ifb.rom_q <= 10'(rom[1][ifb.rom_a]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Frame-level model of one command.
  task automatic mdl_apply(input int s, input int c);
    int a[4], v[4], n[4];
    int hi, lo, sum;
    a[0] = my[s] * W[s] + mx[s]; a[1] = a[0] + 1;
    a[2] = a[0] + W[s];          a[3] = a[2] + 1;
    for (int i = 0; i < 4; i++) begin v[i] = mdl[s][a[i]]; n[i] = v[i]; end
    hi = v[0]; lo = v[0]; sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] > hi) hi = v[i];
      if (v[i] < lo) lo = v[i];
      sum += v[i];
    end
    case (c)
      1:  if (my[s] > 0) my[s]--;
      2:  if (my[s] < H[s] - 2) my[s]++;
      3:  if (mx[s] > 0) mx[s]--;
      4:  if (mx[s] < W[s] - 2) mx[s]++;
      5:  for (int i = 0; i < 4; i++) n[i] = hi;
      6:  for (int i = 0; i < 4; i++) n[i] = lo;
      7:  for (int i = 0; i < 4; i++) n[i] = sum / 4;
      8:  begin n[0] = v[1]; n[1] = v[3]; n[3] = v[2]; n[2] = v[0]; end
      9:  begin n[0] = v[2]; n[2] = v[3]; n[3] = v[1]; n[1] = v[0]; end
      10: begin n[0] = v[2]; n[2] = v[0]; n[1] = v[3]; n[3] = v[1]; end
      11: begin n[0] = v[1]; n[1] = v[0]; n[2] = v[3]; n[3] = v[2]; end
      12: for (int i = 0; i < 4; i++) n[i] = MV[s] - v[i];
      13: begin mx[s] = W[s] / 2 - 1; my[s] = H[s] / 2 - 1; end
      14: for (int i = 0; i < 64; i++) mdl[s][i] = rom[s][i];
      default: ;
    endcase
    if (c >= 5 && c <= 12)
      for (int i = 0; i < 4; i++) mdl[s][a[i]] = n[i];
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) mdl[s][i] = rom[s][i];
      mx[s] = W[s] / 2 - 1;
      my[s] = H[s] / 2 - 1;
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [3:0] c);
    if (s == 0) begin ifa.cmd = c; ifa.cmd_valid = v; end
    else        begin ifb.cmd = c; ifb.cmd_valid = v; end
  endtask

  task automatic wait_idle(input int s, output int n);
    n = 0;
    while (bs[s] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input int s, input logic [3:0] c);
    int n;
    wait_idle(s, n);
    drive(s, 1'b1, c);
    @(negedge clk);
    drive(s, 1'b0, c);
    chk("busy_exec", 32'(bs[s]), 32'd1);
    mdl_apply(s, int'(c));
  endtask

  task automatic write_out(input int s);
    int n;
    send(s, CMD_WR);
    wait_idle(s, n);
  endtask

  task automatic chk_rst(input int s);
    chk("rst_rom_rd",    32'(rr[s]), 0);
    chk("rst_rom_a",     roa[s],     0);
    chk("rst_ram_valid", 32'(rv[s]), 0);
    chk("rst_ram_a",     ra[s],      0);
    chk("rst_ram_d",     rd[s],      0);
    chk("rst_busy",      32'(bs[s]), 1);
    chk("rst_done",      32'(dn[s]), 0);
  endtask

  // Every cycle: ROM address order, RAM stream vs model, done/busy framing.
  int wi;
  always @(negedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        lexp[s] = 0; wexp[s] = 0; plast[s] = 0; pdone[s] = 0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (rr[s]) begin
          chk("rom_a", roa[s], 32'(lexp[s]));
          chk("busy_load", 32'(bs[s]), 1);
          lexp[s]++;
        end else lexp[s] = 0;
        if (rv[s]) begin
          wi = wexp[s] & 63;
          chk("ram_a", ra[s], 32'(wexp[s]));
          chk("ram_d", rd[s], 32'(mdl[s][wi]));
          chk("busy_write", 32'(bs[s]), 1);
          outb[s][wi] = int'(rd[s]);
          wexp[s]++;
        end else wexp[s] = 0;
        chk("done", 32'(dn[s]), 32'(plast[s]));
        if (pdone[s]) chk("busy_after_done", 32'(bs[s]), 0);
        if (dn[s]) begin
          chk("busy_fin", 32'(bs[s]), 1);
          dones[s]++;
        end
        plast[s] = rv[s] && (ra[s] == 63);
        pdone[s] = dn[s];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, d0;
    drive(0, 1'b0, 4'd0);
    drive(1, 1'b0, 4'd0);
    for (int i = 0; i < 64; i++) begin
      rom[0][i] = i;
      rom[1][i] = (i * 13 + 100) % 1024;
    end
    dones[0] = 0; dones[1] = 0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst(0); chk_rst(1);
    mdl_reset();
    reset = 1'b0;
    wait_idle(0, n);
    chk("load_cycles", 32'(n), 32'd66);
    wait_idle(1, n);

    // plain write-out of the ROM image
    write_out(0);
    chk("a_wr0", 32'(outb[0][0]), 0);
    chk("a_wr63", 32'(outb[0][63]), 63);
    chk("a_done_once", 32'(dones[0]), 1);

    // MAX then INV at the home window (3,3)
    send(0, CMD_MAX); write_out(0);
    chk("a_max27", 32'(outb[0][27]), 36);
    chk("a_max36", 32'(outb[0][36]), 36);
    chk("a_max26", 32'(outb[0][26]), 26);
    send(0, CMD_INV); write_out(0);
    chk("a_inv28", 32'(outb[0][28]), 219);
    chk("a_inv35", 32'(outb[0][35]), 219);

    // AVG near the top of the range
    rom[0][27] = 255; rom[0][28] = 255; rom[0][35] = 255; rom[0][36] = 254;
    send(0, CMD_RELOAD);
    send(0, CMD_AVG); write_out(0);
    chk("a_avg27", 32'(outb[0][27]), 254);
    chk("a_avg36", 32'(outb[0][36]), 254);

    // corner window with ignored extra shifts, then CR
    for (int i = 0; i < 64; i++) rom[0][i] = i;
    send(0, CMD_RELOAD);
    for (int i = 0; i < 8; i++) send(0, CMD_UP);
    for (int i = 0; i < 8; i++) send(0, CMD_LEFT);
    send(0, CMD_CR); write_out(0);
    chk("a_cr0", 32'(outb[0][0]), 8);
    chk("a_cr1", 32'(outb[0][1]), 0);
    chk("a_cr9", 32'(outb[0][9]), 1);
    chk("a_cr8", 32'(outb[0][8]), 9);

    // HOME then MIN
    send(0, CMD_HOME); send(0, CMD_MIN); write_out(0);
    chk("a_min36", 32'(outb[0][36]), 27);

    // a command strobed during WRITE is dropped
    send(0, CMD_WR);
    repeat (5) @(negedge clk);
    drive(0, 1'b1, CMD_INV);
    repeat (10) @(negedge clk);
    drive(0, 1'b0, CMD_INV);
    wait_idle(0, n);
    write_out(0);
    chk("a_ignored27", 32'(outb[0][27]), 27);

    // 16x4x10: write, MRY, write, reload, write
    write_out(1);
    chk("b_wr0", 32'(outb[1][0]), 100);
    chk("b_wr63", 32'(outb[1][63]), 919);
    send(1, CMD_MRY); write_out(1);
    chk("b_mry23", 32'(outb[1][23]), 412);
    chk("b_mry24", 32'(outb[1][24]), 399);
    send(1, CMD_RELOAD); write_out(1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (outb[1][i] != rom[1][i]) bad++;
    chk("b_reload_image", 32'(bad), 0);
    for (int i = 0; i < 4; i++) send(1, CMD_DOWN);
    for (int i = 0; i < 16; i++) send(1, CMD_RIGHT);
    send(1, CMD_MAX); write_out(1);
    chk("b_corner63", 32'(outb[1][63]), 919);

    // reset in the middle of a write-out
    send(0, CMD_LEFT);
    send(0, CMD_WR);
    n = 0;
    while (!(rv[0] && ra[0] == 20) && n < 200) begin @(negedge clk); n++; end
    chk("reach_ram_a20", 32'(n < 200), 1);
    reset = 1'b1;
    #1 chk_rst(0);
    repeat (2) @(negedge clk);
    mdl_reset();
    d0 = dones[0];
    reset = 1'b0;
    n = 0;
    while (rr[0] !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    chk("restart_rom_a0", roa[0], 0);
    wait_idle(0, n);
    wait_idle(1, n);
    chk("no_done_after_reset", 32'(dones[0]), 32'(d0));
    send(0, CMD_MAX); write_out(0);
    chk("home_after_reset27", 32'(outb[0][27]), 36);
    chk("home_after_reset26", 32'(outb[0][26]), 26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/img_disp_ctrl_p.md
# img_disp_ctrl_p

Parametrised image display controller for the image-processing contest flow. Loads an IMG_W×IMG_H frame of DW-bit pixels from an external synchronous ROM into an internal buffer. It applies host commands to a movable 2×2 operation window and streams the processed frame to an external RAM. Unlike the fixed 8×8 generation, it adds three commands (invert, home, reload), and it returns to command mode after each write-out, so a frame can be edited and written repeatedly.

## Interface
- IMG_W, 8, image width in pixels (≥2, power of two)
- IMG_H, 8, image height in pixels (≥2)
- DW, 8, pixel width in bits
- AW, $clog2(IMG_W*IMG_H), pixel address width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd  in  4  command code
- cmd_valid  in  1  command strobe; accepted when high and busy low
- rom_q  in  DW  ROM data, valid the cycle after rom_a/rom_rd
- rom_rd  out  1  ROM read enable
- rom_a  out  AW  ROM address
- ram_valid  out  1  RAM write strobe
- ram_a  out  AW  RAM address
- ram_d  out  DW  RAM data
- busy  out  1  high when a command cannot be accepted
- done  out  1  one-cycle pulse after the final RAM write

## Operation
- States: LOAD, IDLE, EXEC, WRITE, FIN. Reset enters LOAD.
- Window: top-left point (px,py). Pixels are P0=(px,py), P1=(px+1,py), P2=(px,py+1), P3=(px+1,py+1). Address = y*IMG_W+x. Reset/HOME value: (IMG_W/2-1, IMG_H/2-1).
- Commands (IDLE, accepted → EXEC for 1 cycle → IDLE):
  - 0 WRITE → WRITE
  - 1 UP: py-1 if py>0
  - 2 DOWN: py+1 if py<IMG_H-2
  - 3 LEFT: px-1 if px>0
  - 4 RIGHT: px+1 if px<IMG_W-2
  - 5 MAX: all four pixels ← max
  - 6 MIN: all four pixels ← min
  - 7 AVG: all four pixels ← floor(sum/4), sum is DW+2 bits, no overflow
  - 8 CCR: P0←P1, P1←P3, P3←P2, P2←P0
  - 9 CR: P0←P2, P2←P3, P3←P1, P1←P0
  - 10 MRX: swap rows (P0↔P2, P1↔P3)
  - 11 MRY: swap columns (P0↔P1, P2↔P3)
  - 12 INV: each pixel ← (2^DW-1)-pixel
  - 13 HOME: window to reset position
  - 14 RELOAD → LOAD
  - 15: no-op, EXEC only
- Out-of-range shifts are silently ignored. Window state persists across WRITE and RELOAD.
- cmd_valid while busy is ignored; no queueing.

## Timing
- Reset values: rom_rd 0, rom_a 0, ram_valid 0, ram_a 0, ram_d 0, busy 1, done 0. Buffer contents are don't-care.
- LOAD:
  - cycles k=0..N-1 (N=IMG_W*IMG_H): rom_rd=1, rom_a=k.
  - rom_q for address k is captured in cycle k+1.
  - Cycle N: rom_rd=0, last capture.
  - Cycle N+1: IDLE, busy=0.
  - The first load begins the first clk after reset deasserts.
- Command latency: cmd accepted at edge t → busy=1 in cycle t+1 (EXEC) → busy=0 at t+2. The buffer or window is updated by edge t+2.
- WRITE:
  - N cycles with ram_valid=1, ram_a=0..N-1 ascending, ram_d=buffer[ram_a]. All three are registered and aligned.
  - The next cycle is FIN: ram_valid=0, done=1, busy=1.
  - The cycle after that is IDLE.
- busy is 1 in LOAD, EXEC, WRITE and FIN; 0 only in IDLE.
- Reset asserted mid-LOAD or mid-WRITE aborts immediately: outputs return to reset values and the window goes home.

## Structure
- Package img_disp_pkg holds:
  - cmd encoding constants (CMD_WR..CMD_RELOAD)
  - state enum
  - window home-position function of IMG_W/IMG_H
- Sub-module img_win_alu: combinational. Takes the four DW-bit window pixels and cmd; returns four new pixel values. Covers MAX/MIN/AVG/CCR/CR/MRX/MRY/INV.
- The top level owns the FSM, the address counter, the window registers and the buffer (register array, 4 write ports in EXEC, 1 in LOAD).

## Test plan
- Default 8×8, ROM[i]=i: load then WRITE → 64 RAM writes with data=i. done pulses once, one cycle after ram_a=63. busy falls the cycle after that.
- Home window (3,3): MAX → addresses 27,28,35,36 all =36. Then INV → all =219.
- AVG on pixels 27,28,35,36 = 255,255,255,254 → all =254 (floor 1019/4). No overflow.
- 8× UP then 8× LEFT → window (0,0); extra UP/LEFT ignored. CR on 0,1,8,9 → addr0=8, addr1=0, addr9=1, addr8=9.
- IMG_W=16, IMG_H=4, DW=10: load, WRITE, modify with MRY, WRITE again, RELOAD, WRITE → the third output equals the ROM image.
- Reset asserted mid-WRITE at ram_a=20 → outputs go to reset values at once. After release, LOAD restarts at rom_a=0 and no done pulse occurs.
